// File: rtl/cpu_dbg_port.sv
// CPU-side debug responder: run/step pipeline enable,
// advanced-cycle counter and regfile/data-memory inspection reads.
module cpu_dbg_port #(
  parameter int MEM_AW = 8,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              succ,
  input  logic              step,
  input  logic              dbg_req,
  input  logic              dbg_m_rf,
  input  logic [MEM_AW-1:0] dbg_addr,
  output logic              dbg_ack,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              cpu_en,
  output logic              halted,
  output logic [4:0]        rf_raddr,
  input  logic [DATA_W-1:0] rf_rdata,
  output logic [MEM_AW-1:0] mem_raddr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [CNT_W-1:0]  adv_cnt
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

  state_t state, state_nxt;

  logic step_q;
  logic step_rise;
  logic m_rf_q;
  logic latch;
  logic capture;

  assign step_rise = step & ~step_q;

  // Run/step enable, halt flag and advanced-cycle counter
  always_ff @(posedge clk) begin
    if (rst) begin
      step_q  <= 1'b0;
      cpu_en  <= 1'b0;
      halted  <= 1'b1;
      adv_cnt <= '0;
    end else begin
      step_q  <= step;
      cpu_en  <= succ | (~succ & step_rise);
      halted  <= ~succ;
      adv_cnt <= adv_cnt + CNT_W'(cpu_en);
    end
  end

  // Read FSM state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Read FSM next state plus latch/capture strobes
  always_comb begin
    state_nxt = state;
    latch     = 1'b0;
    capture   = 1'b0;
    unique case (state)
      IDLE: begin
        if (dbg_req) begin
          latch     = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE: state_nxt = WAIT;
      WAIT: begin
        capture   = 1'b1;
        state_nxt = RESP;
      end
      RESP: begin
        if (dbg_req) begin
          latch     = 1'b1;
          state_nxt = ISSUE;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Address registers, loaded only at latch points
  always_ff @(posedge clk) begin
    if (rst) begin
      rf_raddr  <= '0;
      mem_raddr <= '0;
      m_rf_q    <= 1'b0;
    end else if (latch) begin
      rf_raddr  <= dbg_addr[4:0];
      mem_raddr <= dbg_addr;
      m_rf_q    <= dbg_m_rf;
    end
  end

  // Read-data capture and one-cycle ack; x0 always reads zero
  always_ff @(posedge clk) begin
    if (rst) begin
      dbg_ack   <= 1'b0;
      dbg_rdata <= '0;
    end else begin
      dbg_ack <= capture;
      if (capture) begin
        if (m_rf_q)
          dbg_rdata <= mem_rdata;
        else if (rf_raddr == 5'd0)
          dbg_rdata <= '0;
        else
          dbg_rdata <= rf_rdata;
      end
    end
  end

endmodule

// File: tb/tb_cpu_dbg_port.sv
// Scoreboard bench for cpu_dbg_port: directed run/step/read cases,
// randomized mixed traffic, counter wrap and reset-abort.
module tb_cpu_dbg_port;

  logic        clk = 1'b0;
  logic        rst;
  logic        succ;
  logic        step;
  logic        dbg_req;
  logic        dbg_m_rf;
  logic [7:0]  dbg_addr;
  logic        dbg_ack;
  logic [31:0] dbg_rdata;
  logic        cpu_en;
  logic        halted;
  logic [4:0]  rf_raddr;
  logic [31:0] rf_rdata;
  logic [7:0]  mem_raddr;
  logic [31:0] mem_rdata;
  logic [15:0] adv_cnt;

  cpu_dbg_port dut (
    .clk       (clk),
    .rst       (rst),
    .succ      (succ),
    .step      (step),
    .dbg_req   (dbg_req),
    .dbg_m_rf  (dbg_m_rf),
    .dbg_addr  (dbg_addr),
    .dbg_ack   (dbg_ack),
    .dbg_rdata (dbg_rdata),
    .cpu_en    (cpu_en),
    .halted    (halted),
    .rf_raddr  (rf_raddr),
    .rf_rdata  (rf_rdata),
    .mem_raddr (mem_raddr),
    .mem_rdata (mem_rdata),
    .adv_cnt   (adv_cnt)
  );

  always #5 clk = ~clk;

  // Environment: sync RAM, regfile returning addr*4.
  // x0 drives garbage so the zero-forcing is observable.
  logic [31:0] ram [256];
  always @(posedge clk) mem_rdata <= ram[mem_raddr];
  assign rf_rdata = (rf_raddr == 5'd0) ? 32'hBAD0_BAD0
                                       : {25'b0, rf_raddr, 2'b00};

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int en_seen  = 0;
  bit chk_on   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", n, act, exp);
    end
  endtask

  // Reference model: enable follows the run level, or one
  // pulse per fresh step edge while halted; counter counts enables.
  bit e_en   = 0;
  bit e_halt = 1;
  int e_cnt  = 0;
  bit prev_step = 0;
  always @(posedge clk) begin
    if (rst) begin
      e_en      <= 0;
      e_halt    <= 1;
      e_cnt     <= 0;
      prev_step <= 0;
    end else begin
      e_en      <= succ || (step && !prev_step);
      e_halt    <= !succ;
      e_cnt     <= (e_cnt + (e_en ? 1 : 0)) % 65536;
      prev_step <= step;
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_on) begin
      chk("cpu_en", {31'b0, cpu_en}, {31'b0, e_en});
      chk("halted", {31'b0, halted}, {31'b0, e_halt});
      chk("adv_cnt", {16'b0, adv_cnt}, 32'(e_cnt));
      if (cpu_en) en_seen++;
    end
  end

  typedef struct {
    logic [31:0] data;
    int          due;
  } exp_t;
  exp_t sb[$];

  function automatic logic [31:0] ref_read(bit m, logic [7:0] a);
    if (m) return ram[a];
    if (a[4:0] == 5'd0) return 32'h0;
    return 32'(a[4:0]) * 4;
  endfunction

  // Scoreboard monitor: pops one expectation per ack
  always @(negedge clk) begin
    if (chk_on) begin
      if (dbg_ack) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_ack cyc=%0d rdata=%h", cyc, dbg_rdata);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("rd_data", dbg_rdata, e.data);
          chk("rd_cycle", 32'(cyc), 32'(e.due));
        end
      end else if (sb.size() > 0 && cyc > sb[0].due) begin
        exp_t e;
        e = sb.pop_front();
        checks++;
        failures++;
        $display("FAIL ack_missing cyc=%0d due=%0d", cyc, e.due);
      end
    end
  end

  task automatic wait_ack();
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (dbg_ack) return;
    end
    checks++;
    failures++;
    $display("FAIL ack_timeout cyc=%0d", cyc);
  endtask

  // Single read: request until ack, then release
  task automatic do_read(bit m, logic [7:0] a);
    @(negedge clk);
    dbg_m_rf = m;
    dbg_addr = a;
    dbg_req  = 1'b1;
    sb.push_back('{ref_read(m, a), cyc + 3});
    wait_ack();
    dbg_req = 1'b0;
  endtask

  task automatic press(int hi, int lo);
    step = 1'b1;
    repeat (hi) @(negedge clk);
    step = 1'b0;
    repeat (lo) @(negedge clk);
  endtask

  int b_en;
  int b_cnt;

  initial begin
    for (int i = 0; i < 256; i++) ram[i] = $urandom;
    ram[1] = 32'h0000_0014;
    rst = 1'b1;
    succ = 1'b0;
    step = 1'b0;
    dbg_req = 1'b0;
    dbg_m_rf = 1'b0;
    dbg_addr = 8'h00;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_cpu_en", {31'b0, cpu_en}, 32'h0);
    chk("rst_halted", {31'b0, halted}, 32'h1);
    chk("rst_adv_cnt", {16'b0, adv_cnt}, 32'h0);
    chk("rst_ack", {31'b0, dbg_ack}, 32'h0);
    chk("rst_rdata", dbg_rdata, 32'h0);
    chk("rst_rf_raddr", {27'b0, rf_raddr}, 32'h0);
    chk("rst_mem_raddr", {24'b0, mem_raddr}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    chk_on = 1;

    // Run for 10 cycles
    @(negedge clk);
    #1;
    b_en = en_seen;
    b_cnt = e_cnt;
    succ = 1'b1;
    repeat (10) @(negedge clk);
    succ = 1'b0;
    @(negedge clk);
    chk("run_halted", {31'b0, halted}, 32'h1);
    repeat (2) @(negedge clk);
    #1;
    chk("run_pulses", 32'(en_seen - b_en), 32'd10);
    chk("run_cnt", {16'b0, adv_cnt}, 32'(b_cnt + 10));

    // Six steps, the last held for 5 cycles
    b_en = en_seen;
    b_cnt = e_cnt;
    for (int i = 0; i < 5; i++) press(2, 2);
    press(5, 2);
    #1;
    chk("step_pulses", 32'(en_seen - b_en), 32'd6);
    chk("step_cnt", {16'b0, adv_cnt}, 32'(b_cnt + 6));

    // Step edge while running adds nothing
    succ = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    b_en = en_seen;
    press(2, 2);
    #1;
    chk("run_step_pulses", 32'(en_seen - b_en), 32'd4);

    // Step rises on the same edge succ falls: one pulse
    b_en = en_seen;
    succ = 1'b0;
    step = 1'b1;
    repeat (3) @(negedge clk);
    step = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("same_edge_pulses", 32'(en_seen - b_en), 32'd1);

    // Step held across succ falling: no pulse
    succ = 1'b1;
    step = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    b_en = en_seen;
    succ = 1'b0;
    repeat (4) @(negedge clk);
    step = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("held_step_pulses", 32'(en_seen - b_en), 32'd0);

    // Memory read of word 1
    do_read(1'b1, 8'd1);
    chk("mem_raddr", {24'b0, mem_raddr}, 32'h1);

    // Register refresh: addr 2 twice, then addr 0
    @(negedge clk);
    dbg_m_rf = 1'b0;
    dbg_addr = 8'd2;
    dbg_req  = 1'b1;
    sb.push_back('{32'd8, cyc + 3});
    wait_ack();
    sb.push_back('{32'd8, cyc + 3});
    wait_ack();
    dbg_addr = 8'd0;
    sb.push_back('{32'd0, cyc + 3});
    @(negedge clk);
    dbg_addr = 8'd3;
    wait_ack();
    dbg_req = 1'b0;
    chk("x0_rdata", dbg_rdata, 32'h0);

    // Randomized reads alongside random run/step traffic
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          @(negedge clk);
          if ($urandom_range(0, 9) == 0) succ = ~succ;
          if ($urandom_range(0, 2) == 0) step = ~step;
        end
        succ = 1'b0;
        step = 1'b0;
      end
      begin
        for (int i = 0; i < 30; i++) begin
          do_read(1'($urandom), 8'($urandom));
          repeat ($urandom_range(0, 3)) @(negedge clk);
        end
      end
    join
    repeat (3) @(negedge clk);

    // Reset while in WAIT aborts the read
    do_read(1'b1, 8'd1);
    @(negedge clk);
    dbg_m_rf = 1'b1;
    dbg_addr = 8'd1;
    dbg_req  = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    dbg_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_rdata", dbg_rdata, 32'h0);
    chk("abort_ack", {31'b0, dbg_ack}, 32'h0);
    repeat (5) @(negedge clk);
    chk("abort_sb_empty", 32'(sb.size()), 32'h0);

    // Counter wrap after 65535 advanced cycles
    succ = 1'b1;
    for (int i = 0; i < 70000; i++) begin
      @(negedge clk);
      if (e_cnt == 65535) break;
    end
    chk("pre_wrap_cnt", {16'b0, adv_cnt}, 32'h0000_FFFF);
    @(negedge clk);
    chk("wrap_cnt", {16'b0, adv_cnt}, 32'h0);
    succ = 1'b0;
    repeat (3) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
